// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared constants for the ID-stage pipeline controller: opcode/func codes,
// ALU operation codes, muxctrl bit positions, the NOP bundle and FSM states.
package pipe_ctrl_unit_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    // ALU operation codes
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_SLL = 5'b01101;
    localparam logic [4:0] ALU_SRL = 5'b01110;
    localparam logic [4:0] ALU_SRA = 5'b01111;
    localparam logic [4:0] ALU_SLT = 5'b10000;
    localparam logic [4:0] ALU_NOP = 5'b01101;

    // muxctrl bit positions; the decoder only produces the low MUX_USED_W bits
    localparam int MUX_USED_W   = 10;
    localparam int MUX_MEM2REG  = 2;   // write-back from memory
    localparam int MUX_SRC_A    = 6;   // ALU A from shamt / jump target from register
    localparam int MUX_JUMP     = 7;
    localparam int MUX_ALU_IMM  = 8;   // ALU B from sign-extended immediate
    localparam int MUX_BRANCH   = 9;

    // memctrl = {mem_read, mem_write, reg_write}
    localparam int MEM_RD  = 2;
    localparam int MEM_WR  = 1;
    localparam int MEM_REG = 0;

    localparam logic [MUX_USED_W-1:0] MUX_NOP = '0;
    localparam logic [2:0]            MEM_NOP = 3'b000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage controller bus: instruction/EX status in, stall/flush and the
// registered ID/EX control bundle out. The pipeline side is the master.
interface pipe_ctrl_unit_if #(
    parameter int MUX_W = 16,
    parameter int ALU_W = 5,
    parameter int RA_W  = 5
);
    logic             id_valid;
    logic [31:0]      instr;
    logic             ex_zero;
    logic             ex_ready;
    logic             if_stall;
    logic             id_flush;
    logic             ex_valid;
    logic [MUX_W-1:0] ex_muxctrl;
    logic [2:0]       ex_memctrl;
    logic [ALU_W-1:0] ex_aluctrl;
    logic [RA_W-1:0]  ex_dst;
    logic             illegal;

    modport master (
        output id_valid, instr, ex_zero, ex_ready,
        input  if_stall, id_flush, ex_valid, ex_muxctrl, ex_memctrl,
               ex_aluctrl, ex_dst, illegal
    );

    modport slave (
        input  id_valid, instr, ex_zero, ex_ready,
        output if_stall, id_flush, ex_valid, ex_muxctrl, ex_memctrl,
               ex_aluctrl, ex_dst, illegal
    );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Pure combinational instruction decoder: op/func -> control bundle plus
// the operand/destination usage flags the hazard logic needs.
module ctrl_decode
    import pipe_ctrl_unit_pkg::*;
(
    input  logic [5:0]            op_i,
    input  logic [5:0]            func_i,
    output logic [MUX_USED_W-1:0] muxctrl_o,
    output logic [2:0]            memctrl_o,
    output logic [4:0]            aluctrl_o,
    output logic                  reads_rt_o,
    output logic                  dst_rt_o,   // destination is rt (I-type) rather than rd
    output logic                  illegal_o
);

    // Decode the opcode, falling into the function field for R-type
    always_comb begin
        muxctrl_o  = MUX_NOP;
        memctrl_o  = MEM_NOP;
        aluctrl_o  = ALU_NOP;
        reads_rt_o = 1'b0;
        dst_rt_o   = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                reads_rt_o = 1'b1;
                memctrl_o  = 3'b001;
                case (func_i)
                    F_ADD, F_ADDU: aluctrl_o = ALU_ADD;
                    F_SUB, F_SUBU: aluctrl_o = ALU_SUB;
                    F_AND:         aluctrl_o = ALU_AND;
                    F_OR:          aluctrl_o = ALU_OR;
                    F_NOR:         aluctrl_o = ALU_NOR;
                    F_SLT:         aluctrl_o = ALU_SLT;
                    F_SLL: begin
                        aluctrl_o             = ALU_SLL;
                        muxctrl_o[MUX_SRC_A]  = 1'b1;
                    end
                    F_SRL: begin
                        aluctrl_o             = ALU_SRL;
                        muxctrl_o[MUX_SRC_A]  = 1'b1;
                    end
                    F_SRA: begin
                        aluctrl_o             = ALU_SRA;
                        muxctrl_o[MUX_SRC_A]  = 1'b1;
                    end
                    F_JR: begin
                        // Register jump: no write-back, rt unused
                        reads_rt_o            = 1'b0;
                        memctrl_o             = MEM_NOP;
                        muxctrl_o[MUX_JUMP]   = 1'b1;
                        muxctrl_o[MUX_SRC_A]  = 1'b1;
                    end
                    default: begin
                        reads_rt_o = 1'b0;
                        memctrl_o  = MEM_NOP;
                        illegal_o  = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                aluctrl_o               = ALU_ADD;
                muxctrl_o[MUX_ALU_IMM]  = 1'b1;
                memctrl_o               = 3'b001;
                dst_rt_o                = 1'b1;
            end
            OP_LW: begin
                aluctrl_o               = ALU_ADD;
                muxctrl_o[MUX_ALU_IMM]  = 1'b1;
                muxctrl_o[MUX_MEM2REG]  = 1'b1;
                memctrl_o               = 3'b101;
                dst_rt_o                = 1'b1;
            end
            OP_SW: begin
                aluctrl_o               = ALU_ADD;
                muxctrl_o[MUX_ALU_IMM]  = 1'b1;
                memctrl_o               = 3'b010;
                reads_rt_o              = 1'b1;
            end
            OP_BEQ: begin
                aluctrl_o               = ALU_SUB;
                muxctrl_o[MUX_BRANCH]   = 1'b1;
                reads_rt_o              = 1'b1;
            end
            OP_J: begin
                muxctrl_o[MUX_JUMP]     = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID-stage pipeline controller: decodes the IF/ID instruction into the
// registered ID/EX control bundle, inserts a one-cycle bubble on load-use
// hazards and squashes wrong-path instructions after taken branches/jumps.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int MUX_W      = 16,
    parameter int ALU_W      = 5,
    parameter int RA_W       = 5,
    parameter int BR_PENALTY = 2
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_unit_if.slave bus
);

    localparam int CNT_W = 2;
    // Squash count loaded on a taken branch; FLUSH lasts BR_PENALTY-1 cycles
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (BR_PENALTY > 1) ? CNT_W'(BR_PENALTY - 2) : '0;

    // Instruction fields
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = bus.instr[31:26];
    assign rs           = bus.instr[25:21];
    assign rt           = bus.instr[20:16];
    assign rd           = bus.instr[15:11];
    assign func         = bus.instr[5:0];
    assign unused_shamt = ^bus.instr[10:6];

    // Decoder outputs
    logic [MUX_USED_W-1:0] dec_mux;
    logic [2:0]            dec_mem;
    logic [4:0]            dec_alu;
    logic                  dec_reads_rt;
    logic                  dec_dst_rt;
    logic                  dec_illegal;

    ctrl_decode u_decode (
        .op_i       (op),
        .func_i     (func),
        .muxctrl_o  (dec_mux),
        .memctrl_o  (dec_mem),
        .aluctrl_o  (dec_alu),
        .reads_rt_o (dec_reads_rt),
        .dst_rt_o   (dec_dst_rt),
        .illegal_o  (dec_illegal)
    );

    // ID/EX register and FSM state
    logic             ex_valid_q;
    logic [MUX_W-1:0] ex_muxctrl_q;
    logic [2:0]       ex_memctrl_q;
    logic [ALU_W-1:0] ex_aluctrl_q;
    logic [RA_W-1:0]  ex_dst_q;
    logic             illegal_q;
    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hazard detection against the instruction currently in EX
    logic            ex_is_load;
    logic            br_taken;
    logic            load_use;
    logic [RA_W-1:0] dst_dec;

    assign ex_is_load = ex_valid_q & ex_memctrl_q[MEM_RD];
    assign br_taken   = ex_valid_q &
                        ((ex_muxctrl_q[MUX_BRANCH] & bus.ex_zero) | ex_muxctrl_q[MUX_JUMP]);
    assign load_use   = bus.id_valid & ex_is_load & (ex_dst_q != '0) &
                        ((ex_dst_q == RA_W'(rs)) | (dec_reads_rt & (ex_dst_q == RA_W'(rt))));
    assign dst_dec    = dec_mem[MEM_REG] ? (dec_dst_rt ? RA_W'(rt) : RA_W'(rd)) : '0;

    // Control outputs to the fetch side and the issue decision
    logic if_stall_s;
    logic id_flush_s;
    logic issue_s;

    // State register: FSM state and squash counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: taken branch beats load-use; nothing moves while EX is busy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.ex_ready) begin
            if (br_taken) begin
                state_d = (BR_PENALTY > 1) ? ST_FLUSH : ST_RUN;
                cnt_d   = CNT_LOAD;
            end else begin
                case (state_q)
                    ST_RUN:   if (load_use) state_d = ST_STALL;
                    ST_STALL: state_d = ST_RUN;
                    ST_FLUSH: begin
                        if (cnt_q == '0) state_d = ST_RUN;
                        else             cnt_d   = cnt_q - 1'b1;
                    end
                    default:  state_d = ST_RUN;
                endcase
            end
        end
    end

    // Outputs: flush cancels a coincident stall; squash while in FLUSH
    always_comb begin
        id_flush_s = bus.ex_ready & br_taken;
        if_stall_s = ~bus.ex_ready | (load_use & ~br_taken);
        issue_s    = bus.id_valid & ~br_taken & ~load_use & (state_q != ST_FLUSH);
    end

    // ID/EX register: load decoded bundle or a bubble; hold while EX is busy.
    // illegal is a single-cycle pulse, so it is cleared rather than held.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_muxctrl_q <= '0;
            ex_memctrl_q <= MEM_NOP;
            ex_aluctrl_q <= ALU_W'(ALU_NOP);
            ex_dst_q     <= '0;
            illegal_q    <= 1'b0;
        end else if (bus.ex_ready) begin
            ex_valid_q   <= issue_s;
            ex_muxctrl_q <= issue_s ? MUX_W'(dec_mux) : '0;
            ex_memctrl_q <= issue_s ? dec_mem : MEM_NOP;
            ex_aluctrl_q <= issue_s ? ALU_W'(dec_alu) : ALU_W'(ALU_NOP);
            ex_dst_q     <= issue_s ? dst_dec : '0;
            illegal_q    <= issue_s & dec_illegal;
        end else begin
            illegal_q    <= 1'b0;
        end
    end

    assign bus.if_stall   = if_stall_s;
    assign bus.id_flush   = id_flush_s;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_muxctrl = ex_muxctrl_q;
    assign bus.ex_memctrl = ex_memctrl_q;
    assign bus.ex_aluctrl = ex_aluctrl_q;
    assign bus.ex_dst     = ex_dst_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode latency, load-use stalls,
// branch/jump squashing, backpressure and illegal-opcode reporting.
module tb_pipe_ctrl_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.MUX_W(16), .ALU_W(5), .RA_W(5)) bus ();

    pipe_ctrl_unit #(
        .MUX_W      (16),
        .ALU_W      (5),
        .RA_W       (5),
        .BR_PENALTY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    localparam logic [4:0] A_ADD = 5'b00010;
    localparam logic [4:0] A_SUB = 5'b00110;
    localparam logic [4:0] A_NOP = 5'b01101;

    function automatic logic [31:0] r_op(input int rs, input int rt, input int rd,
                                         input logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic expect_ex(input string tag, input logic v, input logic [4:0] alu,
                             input logic [2:0] mem, input logic [4:0] dst, input logic [15:0] mux);
        check_vec({tag, "/valid"}, 32'(bus.ex_valid),   32'(v));
        check_vec({tag, "/alu"},   32'(bus.ex_aluctrl), 32'(alu));
        check_vec({tag, "/mem"},   32'(bus.ex_memctrl), 32'(mem));
        check_vec({tag, "/dst"},   32'(bus.ex_dst),     32'(dst));
        check_vec({tag, "/mux"},   32'(bus.ex_muxctrl), 32'(mux));
    endtask

    task automatic expect_bubble(input string tag);
        expect_ex(tag, 1'b0, A_NOP, 3'b000, 5'd0, 16'h0000);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.id_valid = 1'b1;
        bus.instr    = r_op(1, 2, 3, 6'b100000);
        bus.ex_zero  = 1'b0;
        bus.ex_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_bubble("reset");
        check_vec("reset/illegal",  32'(bus.illegal),  32'd0);
        check_vec("reset/if_stall", 32'(bus.if_stall), 32'd0);
        check_vec("reset/id_flush", 32'(bus.id_flush), 32'd0);
        reset = 1'b0;

        // ADD then SUB: one-cycle latency
        cycle();
        expect_ex("add", 1'b1, A_ADD, 3'b001, 5'd3, 16'h0000);
        bus.instr = r_op(3, 1, 4, 6'b100010);
        cycle();
        expect_ex("sub", 1'b1, A_SUB, 3'b001, 5'd4, 16'h0000);

        // LW r5 then ADD r6,r5,r2: one stall, bubble, then issue
        bus.instr = i_op(6'b100011, 1, 5);
        cycle();
        expect_ex("lw", 1'b1, A_ADD, 3'b101, 5'd5, 16'h0104);
        bus.instr = r_op(5, 2, 6, 6'b100000);
        #1;
        check_vec("lu/if_stall", 32'(bus.if_stall), 32'd1);
        check_vec("lu/id_flush", 32'(bus.id_flush), 32'd0);
        cycle();
        expect_bubble("lu_bubble");
        check_vec("lu_bubble/if_stall", 32'(bus.if_stall), 32'd0);
        cycle();
        expect_ex("lu_issue", 1'b1, A_ADD, 3'b001, 5'd6, 16'h0000);

        // LW r0 then ADD reading r0: no stall
        bus.instr = i_op(6'b100011, 1, 0);
        cycle();
        expect_ex("lw_r0", 1'b1, A_ADD, 3'b101, 5'd0, 16'h0104);
        bus.instr = r_op(0, 0, 7, 6'b100000);
        #1;
        check_vec("r0/if_stall", 32'(bus.if_stall), 32'd0);
        cycle();
        expect_ex("add_r0", 1'b1, A_ADD, 3'b001, 5'd7, 16'h0000);

        // LW r5 then ADDI r5,r1: rt not read, no stall
        bus.instr = i_op(6'b100011, 1, 5);
        cycle();
        bus.instr = i_op(6'b001000, 1, 5);
        #1;
        check_vec("addi/if_stall", 32'(bus.if_stall), 32'd0);
        cycle();
        expect_ex("addi", 1'b1, A_ADD, 3'b001, 5'd5, 16'h0100);

        // LW r5 then SW r5,0(r2): store data in rt -> stall
        bus.instr = i_op(6'b100011, 1, 5);
        cycle();
        bus.instr = i_op(6'b101011, 2, 5);
        #1;
        check_vec("sw/if_stall", 32'(bus.if_stall), 32'd1);
        cycle();
        check_vec("sw_bubble/valid", 32'(bus.ex_valid), 32'd0);
        cycle();
        expect_ex("sw", 1'b1, A_ADD, 3'b010, 5'd0, 16'h0100);

        // Taken BEQ: flush, bubble, one squashed instr, then resume
        bus.instr = i_op(6'b000100, 1, 2);
        cycle();
        expect_ex("beq", 1'b1, A_SUB, 3'b000, 5'd0, 16'h0200);
        bus.instr   = r_op(1, 2, 8, 6'b100000);
        bus.ex_zero = 1'b1;
        #1;
        check_vec("beq_t/id_flush", 32'(bus.id_flush), 32'd1);
        check_vec("beq_t/if_stall", 32'(bus.if_stall), 32'd0);
        cycle();
        expect_bubble("beq_t_bubble");
        bus.ex_zero = 1'b0;
        bus.instr   = r_op(1, 2, 9, 6'b100000);
        #1;
        check_vec("flush/id_flush", 32'(bus.id_flush), 32'd0);
        cycle();
        expect_bubble("squash");
        bus.instr = r_op(1, 2, 10, 6'b100000);
        cycle();
        expect_ex("post_flush", 1'b1, A_ADD, 3'b001, 5'd10, 16'h0000);

        // Not-taken BEQ: next instruction issues
        bus.instr = i_op(6'b000100, 1, 2);
        cycle();
        bus.instr = r_op(1, 2, 11, 6'b100000);
        #1;
        check_vec("beq_nt/id_flush", 32'(bus.id_flush), 32'd0);
        cycle();
        expect_ex("beq_nt_next", 1'b1, A_ADD, 3'b001, 5'd11, 16'h0000);

        // J, then backpressure for 4 cycles inside FLUSH
        bus.instr = {6'b000010, 26'h0000010};
        cycle();
        expect_ex("j", 1'b1, A_NOP, 3'b000, 5'd0, 16'h0080);
        bus.instr = r_op(1, 2, 12, 6'b100000);
        #1;
        check_vec("j/id_flush", 32'(bus.id_flush), 32'd1);
        cycle();
        expect_bubble("j_bubble");
        bus.ex_ready = 1'b0;
        bus.instr    = r_op(1, 2, 13, 6'b100000);
        #1;
        check_vec("bp/if_stall", 32'(bus.if_stall), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            expect_bubble("bp_frozen");
        end
        bus.ex_ready = 1'b1;
        #1;
        check_vec("bp_rel/if_stall", 32'(bus.if_stall), 32'd0);
        cycle();
        expect_bubble("bp_squash");
        cycle();
        expect_ex("bp_issue", 1'b1, A_ADD, 3'b001, 5'd13, 16'h0000);

        // Backpressure with a live instruction in EX
        bus.instr = r_op(1, 2, 14, 6'b100000);
        cycle();
        bus.ex_ready = 1'b0;
        bus.instr    = r_op(1, 2, 15, 6'b100010);
        cycle();
        cycle();
        expect_ex("live_frozen", 1'b1, A_ADD, 3'b001, 5'd14, 16'h0000);
        bus.ex_ready = 1'b1;
        cycle();
        expect_ex("live_resume", 1'b1, A_SUB, 3'b001, 5'd15, 16'h0000);

        // Illegal opcode: single-cycle pulse with NOP controls
        bus.instr = 32'hFC00_0000;
        cycle();
        check_vec("illegal/pulse", 32'(bus.illegal),    32'd1);
        check_vec("illegal/alu",   32'(bus.ex_aluctrl), 32'(A_NOP));
        check_vec("illegal/mem",   32'(bus.ex_memctrl), 32'd0);
        check_vec("illegal/mux",   32'(bus.ex_muxctrl), 32'd0);
        bus.instr = r_op(1, 2, 16, 6'b100000);
        cycle();
        check_vec("illegal/clear", 32'(bus.illegal), 32'd0);

        // JR r31: jump bundle and flush
        bus.instr = r_op(31, 0, 0, 6'b001000);
        cycle();
        check_vec("jr/mux", 32'(bus.ex_muxctrl), 32'h00C0);
        check_vec("jr/dst", 32'(bus.ex_dst),     32'd0);
        bus.instr = r_op(1, 2, 17, 6'b100000);
        #1;
        check_vec("jr/id_flush", 32'(bus.id_flush), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
